// File: rtl/serial_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_add_ctrl : bit-serial adder, one shared fa cell, one bit per clock. |
// | Optional overflow output enabled by defining SERIAL_ADD_OVF_EN.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Holds the WIDTH-1 low result bits; the MSB comes straight from fa on the last step.
  logic [WIDTH-2:0] ws_q, ws_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s;
  logic fa_cout;
  logic accept;
  logic last_step;

  fa u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign accept    = (state_q == S_IDLE) && start;
  assign last_step = (state_q == S_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_step) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
    sum  = sum_q;
    cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf  = ovf_q;
`endif
  end

  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    ws_d    = ws_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = cin;
      cnt_d   = '0;
      ws_d    = '0;
    end else if (state_q == S_RUN) begin
      ws_d    = {fa_s, ws_q} >> 1;
      a_sh_d  = a_sh_q >> 1;
      b_sh_d  = b_sh_q >> 1;
      carry_d = fa_cout;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last_step) begin
        sum_d  = {fa_s, ws_q};
        cout_d = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
        // carry_q here is the carry into the MSB position.
        ovf_d  = carry_q ^ fa_cout;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      ws_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      ws_q    <= ws_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_serial_add_ctrl : scoreboard bench for serial_add_ctrl at WIDTH=8.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cin_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a_i),
    .b     (b_i),
    .cin   (cin_i),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           n_cmp = 0;
  int           n_err = 0;
  logic         done_prev = 1'b0;
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for sum/cout, signed range for ovf.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t e;
    int   u;
    int   s;
    u      = int'(a) + int'(b) + int'(c);
    e.sum  = u[W-1:0];
    e.cout = u[W];
    s      = int'($signed(a)) + int'($signed(b)) + int'(c);
    e.ovf  = (s > 127) || (s < -128);
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("sum", 32'(sum), 32'(mon_e.sum));
        check("cout", 32'(cout), 32'(mon_e.cout));
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", 32'(ovf), 32'(mon_e.ovf));
`endif
      end
    end
    if (done_prev) check("done_one_cycle", 32'(done), 32'd0);
    done_prev = done;
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit noise);
    exp_t e;
    e = model(a, b, c);
    @(posedge clk);
    #1;
    a_i = a; b_i = b; cin_i = c; start = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("busy_run", 32'(busy), 32'd1);
      check("done_run", 32'(done), 32'd0);
      check("sum_stable", 32'(sum), 32'(last_sum));
      check("cout_stable", 32'(cout), 32'(last_cout));
      start = noise && (i == 2);
      if (noise) begin
        a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom);
      end
    end
    start = 1'b0;
    @(negedge clk);
    check("busy_done", 32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    last_sum  = e.sum;
    last_cout = e.cout;
    @(negedge clk);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'd0);
    check({tag, "_cout"}, 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'd0);
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    do_op(8'h00, 8'h00, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0);
    do_op(8'hA5, 8'h5A, 1'b1, 1'b0);
    do_op(8'h3C, 8'h4D, 1'b0, 1'b1);

    // Abandon an operation at bit-step 4 with an asynchronous reset.
    @(posedge clk);
    #1;
    a_i = 8'hFF; b_i = 8'hFF; cin_i = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrun_reset");
    repeat (W + 2) @(negedge clk);
    check_reset_outputs("held_reset");
    rst = 1'b0;
    last_sum  = '0;
    last_cout = 1'b0;
    @(negedge clk);
    do_op(8'hFF, 8'hFF, 1'b0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
